// File: rtl/axi_lite_tl_host_bridge.sv
// AXI4-Lite subordinate to TL-UL host bridge.
// Converts single-beat AXI reads/writes into 32-bit TL-UL Get / PutFullData / PutPartialData
// requests, one transaction outstanding at a time. The TL request is fully registered;
// integrity bits are derived from those registered fields.

package axi_lite_tl_host_bridge_pkg;

  localparam logic [2:0] TlPutFullData    = 3'h0;
  localparam logic [2:0] TlPutPartialData = 3'h1;
  localparam logic [2:0] TlGet            = 3'h4;

  localparam logic [2:0] TlAccessAck      = 3'h0;
  localparam logic [2:0] TlAccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module axi_lite_tl_host_bridge
  import axi_lite_tl_host_bridge_pkg::*;
#(
  parameter logic [31:0] TlBaseAddr = 32'h8000_0000,
  parameter logic [7:0]  SourceId   = 8'h00
) (
  input  logic        clk_peri_i,
  input  logic        rst_peri_ni,

  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,

  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StTlReq,
    StTlRsp,
    StAxiB,
    StAxiR
  } state_e;

  state_e      r_state;
  state_e      w_state_d;

  // Latched AXI request channels
  logic        r_aw_held;
  logic [31:0] r_awaddr;
  logic        r_w_held;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_ar_held;
  logic [31:0] r_araddr;

  // Arbitration and current transaction
  logic        r_last_was_write;
  logic        r_is_write;

  // Registered TL A-channel
  logic        r_a_valid;
  logic [2:0]  r_a_opcode;
  logic [31:0] r_a_address;
  logic [3:0]  r_a_mask;
  logic [31:0] r_a_data;

  // AXI response registers
  logic [1:0]  r_bresp;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_wr_rdy;
  logic        w_rd_rdy;
  logic        w_pick_write;
  logic        w_launch;
  logic [31:0] w_addr;
  logic        w_misaligned;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_d_hs;
  logic        w_d_err;
  logic        w_unused_tl;

  // Hamming parity over a payload: payload bit i feeds parity bit k when bit k of (i+1) is set.
  function automatic logic [6:0] intg_parity(input logic [56:0] payload);
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 57; i++) begin
        if ((((i + 1) >> k) % 2) == 1) begin
          p[k] = p[k] ^ payload[i];
        end
      end
    end
    return p;
  endfunction

  assign w_wr_rdy = r_aw_held & r_w_held;
  assign w_rd_rdy = r_ar_held;
  // With both candidates ready, alternate; reset value of r_last_was_write makes reads win first.
  assign w_pick_write = w_wr_rdy & (~w_rd_rdy | ~r_last_was_write);
  assign w_launch     = (r_state == StIdle) & (w_wr_rdy | w_rd_rdy);
  assign w_addr       = w_pick_write ? r_awaddr : r_araddr;
  assign w_misaligned = |w_addr[1:0];

  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_d_hs  = (r_state == StTlRsp) & tl_i.d_valid;

  // A wrong response opcode is reported like a device error.
  assign w_d_err = tl_i.d_error |
                   (r_is_write ? (tl_i.d_opcode != TlAccessAck)
                               : (tl_i.d_opcode != TlAccessAckData));

  assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink};

  // FSM state register
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_launch) begin
          if (w_misaligned) begin
            w_state_d = w_pick_write ? StAxiB : StAxiR;
          end else begin
            w_state_d = StTlReq;
          end
        end
      end
      StTlReq: if (tl_i.a_ready)  w_state_d = StTlRsp;
      StTlRsp: if (tl_i.d_valid)  w_state_d = r_is_write ? StAxiB : StAxiR;
      StAxiB:  if (s_axi_bready)  w_state_d = StIdle;
      StAxiR:  if (s_axi_rready)  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // AXI handshake outputs and response channels
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_bresp   = r_bresp;
    s_axi_rresp   = r_rresp;
    s_axi_rdata   = r_rdata;
    if (r_state == StIdle) begin
      s_axi_awready = ~r_aw_held;
      s_axi_wready  = ~r_w_held;
      s_axi_arready = ~r_ar_held;
    end
    if (r_state == StAxiB) s_axi_bvalid = 1'b1;
    if (r_state == StAxiR) s_axi_rvalid = 1'b1;
  end

  // TL host request, built from registered fields so it stays stable under back-pressure
  always_comb begin
    tl_o                    = '0;
    tl_o.a_valid            = r_a_valid;
    tl_o.a_opcode           = r_a_opcode;
    tl_o.a_param            = 3'h0;
    tl_o.a_size             = 2'd2;
    tl_o.a_source           = SourceId;
    tl_o.a_address          = r_a_address;
    tl_o.a_mask             = r_a_mask;
    tl_o.a_data             = r_a_data;
    tl_o.a_user.cmd_intg    = intg_parity({14'h0, r_a_address, r_a_opcode, r_a_mask, 4'h0});
    tl_o.a_user.data_intg   = intg_parity({25'h0, r_a_data});
    tl_o.d_ready            = (r_state == StTlRsp);
  end

  // Channel latches, request launch and response capture
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) begin
      r_aw_held        <= 1'b0;
      r_awaddr         <= '0;
      r_w_held         <= 1'b0;
      r_wdata          <= '0;
      r_wstrb          <= '0;
      r_ar_held        <= 1'b0;
      r_araddr         <= '0;
      r_last_was_write <= 1'b1;
      r_is_write       <= 1'b0;
      r_a_valid        <= 1'b0;
      r_a_opcode       <= TlGet;
      r_a_address      <= '0;
      r_a_mask         <= '0;
      r_a_data         <= '0;
      r_bresp          <= RespOkay;
      r_rresp          <= RespOkay;
      r_rdata          <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_ar_hs) begin
        r_ar_held <= 1'b1;
        r_araddr  <= s_axi_araddr;
      end

      if ((r_state == StAxiB) && s_axi_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if ((r_state == StAxiR) && s_axi_rready) begin
        r_ar_held <= 1'b0;
      end

      if (w_launch) begin
        r_is_write       <= w_pick_write;
        r_last_was_write <= w_pick_write;
        if (w_misaligned) begin
          if (w_pick_write) begin
            r_bresp <= RespSlverr;
          end else begin
            r_rresp <= RespSlverr;
            r_rdata <= '0;
          end
        end else begin
          r_a_valid   <= 1'b1;
          r_a_address <= {w_addr[31:2], 2'b00} + TlBaseAddr;
          if (w_pick_write) begin
            r_a_opcode <= (r_wstrb == 4'hF) ? TlPutFullData : TlPutPartialData;
            r_a_mask   <= r_wstrb;
            r_a_data   <= r_wdata;
          end else begin
            r_a_opcode <= TlGet;
            r_a_mask   <= 4'hF;
            r_a_data   <= '0;
          end
        end
      end

      if ((r_state == StTlReq) && tl_i.a_ready) begin
        r_a_valid <= 1'b0;
      end

      if (w_d_hs) begin
        if (r_is_write) begin
          r_bresp <= w_d_err ? RespSlverr : RespOkay;
        end else begin
          r_rresp <= w_d_err ? RespSlverr : RespOkay;
          r_rdata <= tl_i.d_data;
        end
      end
    end
  end

endmodule
